// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch-to-decode decoupling queue with JAL/misalign predecode
// Optional same-cycle empty-queue bypass when IFQ_BYPASS_EN is defined.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic                     out_is_jal,
  output logic                     out_misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Payload storage; never reset, outputs are masked while empty
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  jal_mem;
  logic [DEPTH-1:0]  mis_mem;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic push;
  logic pop;
  logic do_wr;
  logic do_rd;
  logic in_is_jal;
  logic in_misalign;

  assign empty       = (count_q == '0);
  assign in_ready    = (count_q != FULL_CNT);
  assign in_is_jal   = (in_inst[6:0] == 7'b1101111);
  assign in_misalign = (in_pc[1:0] != 2'b00);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign count       = count_q;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  // An empty queue forwards fetch straight to decode unless a redirect is in flight
  assign bypass    = empty & in_valid & ~flush;
  assign out_valid = ~empty | bypass;
  // A bypassed entry taken by decode never touches storage
  assign do_wr     = push & ~(bypass & out_ready);
  assign do_rd     = pop & ~empty;

  // Head payload: storage when occupied, live input when bypassing, else zero
  always_comb begin
    out_pc       = '0;
    out_inst     = '0;
    out_is_jal   = 1'b0;
    out_misalign = 1'b0;
    if (!empty) begin
      out_pc       = pc_mem[rd_ptr_q];
      out_inst     = inst_mem[rd_ptr_q];
      out_is_jal   = jal_mem[rd_ptr_q];
      out_misalign = mis_mem[rd_ptr_q];
    end else if (bypass) begin
      out_pc       = in_pc;
      out_inst     = in_inst;
      out_is_jal   = in_is_jal;
      out_misalign = in_misalign;
    end
  end
`else
  assign out_valid = ~empty;
  assign do_wr     = push;
  assign do_rd     = pop;

  // Head payload from storage, zero while empty
  always_comb begin
    out_pc       = '0;
    out_inst     = '0;
    out_is_jal   = 1'b0;
    out_misalign = 1'b0;
    if (!empty) begin
      out_pc       = pc_mem[rd_ptr_q];
      out_inst     = inst_mem[rd_ptr_q];
      out_is_jal   = jal_mem[rd_ptr_q];
      out_misalign = mis_mem[rd_ptr_q];
    end
  end
`endif

  // Next pointer/occupancy; a redirect discards this cycle's push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; reset wins over everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Capture payload and predecode bits at enqueue
  always_ff @(posedge clk) begin
    if (rst && !flush && do_wr) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
      jal_mem[wr_ptr_q]  <= in_is_jal;
      mis_mem[wr_ptr_q]  <= in_misalign;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_is_jal;
  logic        out_misalign;
  logic [2:0]  count;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(64), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_is_jal(out_is_jal), .out_misalign(out_misalign), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_bypass();
`ifdef IFQ_BYPASS_EN
    return (exp_q.size() == 0) && in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compare visible DUT state against the reference queue mid-cycle
  always @(negedge clk) begin
    ent_t head;
    bit   byp;
    bit   exp_valid;
    byp       = model_bypass();
    exp_valid = (exp_q.size() != 0) || byp;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
    if (exp_valid) begin
      head = (exp_q.size() != 0) ? exp_q[0] : '{pc: in_pc, inst: in_inst};
      chk("head_pc", out_pc, head.pc);
      chk("head_inst", 64'(out_inst), 64'(head.inst));
      chk("head_is_jal", 64'(out_is_jal), 64'(head.inst[6:0] == 7'h6F));
      chk("head_misalign", 64'(out_misalign), 64'(head.pc[1:0] != 2'b00));
    end else begin
      chk("empty_pc", out_pc, 64'h0);
      chk("empty_inst", 64'(out_inst), 64'h0);
      chk("empty_flags", 64'({out_is_jal, out_misalign}), 64'h0);
    end
  end

  // Reference model: ordered queue updated from the handshake rules
  always @(posedge clk) begin
    int n;
    n = exp_q.size();
    if (!rst || flush) begin
      exp_q.delete();
    end else if (model_bypass() && out_ready) begin
      // consumed directly from fetch
    end else begin
      if (out_ready && n != 0) void'(exp_q.pop_front());
      if (in_valid && n != DEPTH) exp_q.push_back('{pc: in_pc, inst: in_inst});
    end
  end

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] pc;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_inst = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_count", 64'(count), 64'h0);
    chk("reset_out_pc", out_pc, 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b1;

    // fill and drain
    for (int i = 0; i < 4; i++) drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h13, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'h0);
    for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_count", 64'(count), 64'h0);

    // full refusal, then retry lands last
    for (int i = 0; i < 4; i++) drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h13, 1'b0, 1'b0);
    drive(1'b1, 64'h8000_0010, 32'h13, 1'b1, 1'b0);
    chk("refuse_in_ready_next", 64'(in_ready), 64'h1);
    drive(1'b1, 64'h8000_0010, 32'h13, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // streaming with wrap
    for (int i = 0; i < 10; i++) drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h13, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // predecode
    drive(1'b1, 64'h8000_0000, 32'h0000_006F, 1'b0, 1'b0);
    drive(1'b1, 64'h8000_0002, 32'h0000_0013, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("predecode_jal", 64'({out_is_jal, out_misalign}), 64'b10);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    chk("predecode_mis", 64'({out_is_jal, out_misalign}), 64'b01);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // flush discards contents and the concurrent push
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h8000_0020 + 64'(4 * i), 32'h13, 1'b0, 1'b0);
    drive(1'b1, 64'h8000_0100, 32'h13, 1'b0, 1'b1);
    in_valid = 1'b0;
    #1;
    chk("flush_count", 64'(count), 64'h0);
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    drive(1'b1, 64'h8000_0200, 32'h13, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("post_flush_head", out_pc, 64'h8000_0200);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

`ifdef IFQ_BYPASS_EN
    in_valid  = 1'b1;
    in_pc     = 64'h8000_0000;
    in_inst   = 32'h13;
    out_ready = 1'b1;
    #1;
    chk("bypass_valid", 64'(out_valid), 64'h1);
    chk("bypass_pc", out_pc, 64'h8000_0000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    chk("bypass_count", 64'(count), 64'h0);
`endif

    // randomized traffic with occasional flush and reset
    pc = 64'h8000_0000;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 3) == 0) inst[6:0] = 7'h6F;
      if ($urandom_range(0, 4) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      rst = ($urandom_range(0, 63) != 0);
      drive(1'($urandom_range(0, 2) != 0), pc, inst, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0));
      pc = {pc[63:2], 2'b00} + 64'd4;
    end
    rst = 1'b1;
    idle();
    for (int i = 0; i < 6; i++) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
